// File: rtl/fifo_vr_if.sv
// fifo_vr_if: valid/ready handshake bundle for fifo_vr.
//   Signal suffixes are from the FIFO's point of view.
//   s_data_i  / s_valid_i / s_ready_o : write side (producer -> FIFO)
//   m_data_o  / m_valid_o / m_ready_i : read side  (FIFO -> consumer)
//   modport slave  : the FIFO itself
//   modport master : the environment driving the FIFO (producer + consumer)
interface fifo_vr_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] s_data_i;
    logic                  s_valid_i;
    logic                  s_ready_o;
    logic [DATA_WIDTH-1:0] m_data_o;
    logic                  m_valid_o;
    logic                  m_ready_i;

    modport slave (
        input  s_data_i,
        input  s_valid_i,
        output s_ready_o,
        output m_data_o,
        output m_valid_o,
        input  m_ready_i
    );

    modport master (
        output s_data_i,
        output s_valid_i,
        input  s_ready_o,
        input  m_data_o,
        input  m_valid_o,
        output m_ready_i
    );
endinterface

// File: rtl/fifo_vr.sv
// fifo_vr: single-clock FIFO with valid/ready on both sides, programmable
// almost-full/almost-empty levels, synchronous flush and a high-water mark.
//
// Build option: FIFO_VR_OUT_REG_EN
//   defined   : head entry is prefetched into an output register, so m_data_o /
//               m_valid_o come straight from flops. Capacity FIFO_DEPTH+1.
//   undefined : m_data_o is read combinationally from memory. Capacity FIFO_DEPTH.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          synchronous active-low reset
//   bus            fifo_vr_if.slave (write and read handshakes)
//   flush_i        synchronous clear of contents and high-water mark
//   af_thresh_i    almost-full level  (almost_full_o  = count_o >= af_thresh_i)
//   ae_thresh_i    almost-empty level (almost_empty_o = count_o <= ae_thresh_i)
//   almost_full_o  / almost_empty_o  watermark flags
//   count_o        entries held (includes the output register when present)
//   max_count_o    highest count_o since reset or flush
//
// FIFO_DEPTH must be a power of two and at least 4.
module fifo_vr #(
    parameter int  DATA_WIDTH = 8,
    parameter int  FIFO_DEPTH = 32,
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_vr_if.slave          bus,
    input  logic              flush_i,
    input  logic [ADDR_WIDTH:0] af_thresh_i,
    input  logic [ADDR_WIDTH:0] ae_thresh_i,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [ADDR_WIDTH:0] count_o,
    output logic [ADDR_WIDTH:0] max_count_o
);

    localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic [ADDR_WIDTH:0] max_q, max_d;

    logic mem_full;
    logic mem_empty;
    logic wr_en;
    logic rd_en;
    logic mem_pop;

    // Pointer MSB is wrap parity: equal low bits with differing MSB means full.
    assign mem_full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                       (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    assign mem_empty = (wr_ptr_q == rd_ptr_q);

    // Ready comes from registered memory state only, so a read in a full cycle
    // does not open the write side until the next cycle.
    assign bus.s_ready_o = rst_n & ~mem_full;

    // Flush wins over any handshake in the same cycle; the write is dropped.
    assign wr_en = bus.s_valid_i & bus.s_ready_o & ~flush_i;
    assign rd_en = bus.m_valid_o & bus.m_ready_i & ~flush_i;

`ifdef FIFO_VR_OUT_REG_EN
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    // Prefetch whenever the output register is empty or is being drained.
    assign mem_pop = ~mem_empty & (~out_valid_q | rd_en);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (mem_pop) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end else if (rd_en) begin
            out_valid_d = 1'b0;
        end
        if (flush_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
        out_data_q <= out_data_d;
    end

    assign bus.m_valid_o = rst_n & out_valid_q;
    assign bus.m_data_o  = out_data_q;
`else
    assign mem_pop       = rd_en;
    assign bus.m_valid_o = rst_n & ~mem_empty;
    assign bus.m_data_o  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        max_d    = max_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            max_d    = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + ONE;
            end
            if (mem_pop) begin
                rd_ptr_d = rd_ptr_q + ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
            // Track against the next count so max_count_o never lags count_o.
            if (count_d > max_q) begin
                max_d = count_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            max_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            max_q    <= max_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.s_data_i;
        end
    end

    assign count_o        = count_q;
    assign max_count_o    = max_q;
    assign almost_full_o  = (count_q >= af_thresh_i);
    assign almost_empty_o = (count_q <= ae_thresh_i);

endmodule

// File: tb/tb_fifo_vr.sv
// tb_fifo_vr: self-checking bench for fifo_vr (DATA_WIDTH 8, FIFO_DEPTH 32).
// Covers both builds; FIFO_VR_OUT_REG_EN changes capacity and head latency.
module tb_fifo_vr;

    localparam int DEPTH = 32;
`ifdef FIFO_VR_OUT_REG_EN
    localparam int CAP     = DEPTH + 1;
    localparam int VIS_LAT = 1;
`else
    localparam int CAP     = DEPTH;
    localparam int VIS_LAT = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       flush_i;
    logic [5:0] af_thresh;
    logic [5:0] ae_thresh;
    logic       almost_full;
    logic       almost_empty;
    logic [5:0] count;
    logic [5:0] max_count;

    fifo_vr_if #(.DATA_WIDTH(8)) bus ();

    fifo_vr #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .flush_i        (flush_i),
        .af_thresh_i    (af_thresh),
        .ae_thresh_i    (ae_thresh),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty),
        .count_o        (count),
        .max_count_o    (max_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       mr;
        logic [7:0] exp_rd;
        int         exp_cnt;
        int         exp_max;
        logic       exp_af;
        logic       exp_ae;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        int         e;
    } ent_t;

    vec_t vecs[14];
    ent_t mq[$];
    int   mx;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int nr;
        int n_early;
        int pw;
        int pr;
        logic vis;
        logic exp_rdy;
        logic exp_val;

        // af=4, ae=1 throughout the table
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 8'h00, 1, 1, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 8'h12, 1'b0, 8'h00, 2, 2, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h13, 1'b0, 8'h00, 3, 3, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h14, 1'b0, 8'h00, 4, 4, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'h15, 1'b0, 8'h00, 5, 5, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 8'h16, 1'b1, 8'h11, 5, 5, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 8'h12, 4, 5, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 8'h13, 3, 5, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 3, 5, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 8'h14, 2, 5, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 8'h15, 1, 5, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 8'h17, 1'b0, 8'h00, 2, 5, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 8'h16, 1, 5, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 8'h17, 0, 5, 1'b0, 1'b1};

        // Reset with a pending write and read request
        rst_n         = 1'b0;
        flush_i       = 1'b0;
        af_thresh     = 6'd0;
        ae_thresh     = 6'd0;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 8'hAA;
        bus.m_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_s_ready", bus.s_ready_o, 1'b0);
            check("rst_m_valid", bus.m_valid_o, 1'b0);
        end
        check("rst_count", count, 0);
        check("rst_max", max_count, 0);
        check("rst_af_zero_thresh", almost_full, 1'b1);
        rst_n         = 1'b1;
        bus.s_valid_i = 1'b0;
        bus.m_ready_i = 1'b0;
        #1;
        check("post_rst_s_ready", bus.s_ready_o, 1'b1);
        check("post_rst_m_valid", bus.m_valid_o, 1'b0);
        check("post_rst_ae", almost_empty, 1'b1);

        // Table: thresholds, simultaneous read/write, ordering
        af_thresh = 6'd4;
        ae_thresh = 6'd1;
        for (int i = 0; i < 14; i++) begin
            bus.s_valid_i = vecs[i].sv;
            bus.s_data_i  = vecs[i].sd;
            bus.m_ready_i = vecs[i].mr;
            #1;
            if (vecs[i].mr) begin
                check("tbl_m_valid", bus.m_valid_o, 1'b1);
                check("tbl_rdata", bus.m_data_o, vecs[i].exp_rd);
            end
            tick();
            check("tbl_count", count, vecs[i].exp_cnt);
            check("tbl_max", max_count, vecs[i].exp_max);
            check("tbl_af", almost_full, vecs[i].exp_af);
            check("tbl_ae", almost_empty, vecs[i].exp_ae);
        end
        bus.m_ready_i = 1'b0;

        // Threshold change takes effect combinationally
        for (int i = 0; i < 3; i++) begin
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = 8'(8'h31 + i);
            tick();
        end
        bus.s_valid_i = 1'b0;
        #1;
        check("thr_count3", count, 3);
        check("thr_af4", almost_full, 1'b0);
        af_thresh = 6'd2;
        #1;
        check("thr_af2_same_cycle", almost_full, 1'b1);
        af_thresh = 6'd4;

        // Flush at count 7 with a concurrent write
        for (int i = 0; i < 4; i++) begin
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = 8'(8'h34 + i);
            tick();
        end
        check("pre_flush_count", count, 7);
        check("pre_flush_max", max_count, 7);
        flush_i       = 1'b1;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 8'hEE;
        tick();
        flush_i       = 1'b0;
        bus.s_valid_i = 1'b0;
        #1;
        check("flush_count", count, 0);
        check("flush_max", max_count, 0);
        check("flush_m_valid", bus.m_valid_o, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("flush_drop_m_valid", bus.m_valid_o, 1'b0);
            check("flush_drop_count", count, 0);
        end
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 8'h5A;
        tick();
        bus.s_valid_i = 1'b0;
        tick();
        check("post_flush_m_valid", bus.m_valid_o, 1'b1);
        check("post_flush_data", bus.m_data_o, 8'h5A);
        bus.m_ready_i = 1'b1;
        tick();
        bus.m_ready_i = 1'b0;
        check("post_flush_count", count, 0);
        check("post_flush_empty", bus.m_valid_o, 1'b0);

        // Fill to capacity, extra write held, read at full, drain
        for (int i = 1; i <= CAP; i++) begin
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = 8'(i);
            #1;
            check("fill_ready", bus.s_ready_o, 1'b1);
            tick();
        end
        bus.s_data_i = 8'(CAP + 1);
        #1;
        check("full_ready", bus.s_ready_o, 1'b0);
        check("full_count", count, CAP);
        check("full_max", max_count, CAP);
        tick();
        tick();
        check("full_hold_count", count, CAP);
        check("full_hold_ready", bus.s_ready_o, 1'b0);
        bus.m_ready_i = 1'b1;
        #1;
        check("full_rw_ready", bus.s_ready_o, 1'b0);
        check("full_rw_m_valid", bus.m_valid_o, 1'b1);
        check("full_rw_data", bus.m_data_o, 8'h01);
        tick();
        bus.s_valid_i = 1'b0;
        check("full_rw_count", count, CAP - 1);
        for (int i = 2; i <= CAP; i++) begin
            #1;
            check("drain_m_valid", bus.m_valid_o, 1'b1);
            check("drain_data", bus.m_data_o, 8'(i));
            tick();
        end
        bus.m_ready_i = 1'b0;
        #1;
        check("drain_done_m_valid", bus.m_valid_o, 1'b0);
        check("drain_done_count", count, 0);
        check("drain_keep_max", max_count, CAP);

        // Streaming across the pointer wrap at one transfer per cycle
        nr            = 0;
        bus.m_ready_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = 8'(8'h80 + i);
            #1;
            check("stream_ready", bus.s_ready_o, 1'b1);
            if (bus.m_valid_o) begin
                check("stream_data", bus.m_data_o, 8'(8'h80 + nr));
                nr++;
            end
            tick();
        end
        n_early       = nr;
        bus.s_valid_i = 1'b0;
        for (int i = 0; i < 10 && nr < 40; i++) begin
            #1;
            if (bus.m_valid_o) begin
                check("stream_data", bus.m_data_o, 8'(8'h80 + nr));
                nr++;
            end
            tick();
        end
        check("stream_throughput", n_early, 40 - 1 - VIS_LAT);
        check("stream_total", nr, 40);
        bus.m_ready_i = 1'b0;
        #1;
        check("stream_end_count", count, 0);
        check("stream_end_m_valid", bus.m_valid_o, 1'b0);

        // Randomized traffic against a queue model
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        mq.delete();
        mx = 0;
        pw = 50;
        pr = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) begin
                case ((c / 500) % 4)
                    0: begin pw = 90;  pr = 10;  end
                    1: begin pw = 10;  pr = 90;  end
                    2: begin pw = 60;  pr = 60;  end
                    default: begin pw = 100; pr = 100; end
                endcase
            end
            bus.s_valid_i = ($urandom_range(0, 99) < pw);
            bus.s_data_i  = 8'($urandom);
            bus.m_ready_i = ($urandom_range(0, 99) < pr);
            flush_i       = ($urandom_range(0, 199) == 0);
            rst_n         = !(c >= 2000 && c < 2002);
            if ($urandom_range(0, 49) == 0) af_thresh = 6'($urandom_range(0, CAP));
            if ($urandom_range(0, 49) == 0) ae_thresh = 6'($urandom_range(0, CAP));
            #1;
            vis = (mq.size() > 0) && (edge_n >= mq[0].e + VIS_LAT);
`ifdef FIFO_VR_OUT_REG_EN
            exp_rdy = rst_n && ((mq.size() - (vis ? 1 : 0)) < DEPTH);
`else
            exp_rdy = rst_n && (mq.size() < DEPTH);
`endif
            exp_val = rst_n && vis;
            check("rnd_s_ready", bus.s_ready_o, exp_rdy);
            check("rnd_m_valid", bus.m_valid_o, exp_val);
            check("rnd_count", count, mq.size());
            check("rnd_max", max_count, mx);
            check("rnd_af", almost_full, mq.size() >= int'(af_thresh));
            check("rnd_ae", almost_empty, mq.size() <= int'(ae_thresh));
            if (exp_val) begin
                check("rnd_data", bus.m_data_o, mq[0].d);
            end
            if (!rst_n || flush_i) begin
                mq.delete();
                mx = 0;
            end else begin
                if (exp_val && bus.m_ready_i) void'(mq.pop_front());
                if (exp_rdy && bus.s_valid_i) mq.push_back('{bus.s_data_i, edge_n + 1});
                if (mq.size() > mx) mx = mq.size();
            end
            tick();
        end
        rst_n         = 1'b1;
        flush_i       = 1'b0;
        bus.s_valid_i = 1'b0;
        bus.m_ready_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_vr.md
# fifo_vr

Synchronous single-clock FIFO with valid/ready handshakes on both sides, runtime-programmable almost-full/almost-empty thresholds, a synchronous flush and a high-water-mark counter. It is the next-generation buffer in the common library, for streaming datapaths that need backpressure-correct flow control and watermark-driven scheduling.

## Interface
- DATA_WIDTH, 8, payload width in bits
- FIFO_DEPTH, 32, storage entries; power of two, at least 4
- ADDR_WIDTH, $clog2(FIFO_DEPTH), derived; not overridden
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- s_data_i  in  DATA_WIDTH  write payload
- s_valid_i  in  1  write request
- s_ready_o  out  1  space available; a write is accepted when s_valid_i & s_ready_o
- m_data_o  out  DATA_WIDTH  head-of-queue payload
- m_valid_o  out  1  head entry present
- m_ready_i  in  1  consumer accepts; a read is accepted when m_valid_o & m_ready_i
- flush_i  in  1  synchronous clear of contents
- af_thresh_i  in  ADDR_WIDTH+1  almost-full level
- ae_thresh_i  in  ADDR_WIDTH+1  almost-empty level
- almost_full_o  out  1  count_o >= af_thresh_i
- almost_empty_o  out  1  count_o <= ae_thresh_i
- count_o  out  ADDR_WIDTH+1  entries held, including the output register if present
- max_count_o  out  ADDR_WIDTH+1  highest count_o reached since reset or flush

## Operation
- Storage is FIFO_DEPTH x DATA_WIDTH memory with ADDR_WIDTH+1-bit wr/rd pointers. The MSB carries wrap parity. Memory is not reset.
- Memory full: pointers are equal in the low ADDR_WIDTH bits and differ in the MSB. Memory empty: pointers are fully equal. Pointers wrap naturally modulo 2*FIFO_DEPTH.
- s_ready_o = !full. It depends only on registered state and has no combinational path from m_ready_i.
- When full, a simultaneous read does not enable a write in the same cycle. The freed slot is visible in the next cycle.
- Simultaneous accepted read and write leaves count_o unchanged.
- count_o is a register updated as +1 on write only, -1 on read only, and unchanged otherwise. It never exceeds capacity and never underflows.
- almost_full_o and almost_empty_o are combinational compares on count_o. af_thresh_i = 0 forces almost_full_o high. Thresholds may change on any cycle.
- max_count_o is updated to count_o whenever count_o exceeds it. It is cleared by reset and by flush.
- flush_i resets pointers, count_o, max_count_o and output-register valid in the same edge. It has priority over a write or read in that cycle, and that write is dropped.
- m_data_o is don't-care while m_valid_o is low.
- Reset values: s_ready_o 0 while rst_n low and 1 from the first cycle after; m_valid_o 0; count_o 0; max_count_o 0; almost_empty_o 1; almost_full_o = (af_thresh_i == 0).
- Reset asserted mid-transfer discards all contents. No accepted handshake completes in a reset cycle.

## Timing
- Write-to-read latency without FIFO_VR_OUT_REG_EN: a write accepted at edge N gives m_valid_o high and m_data_o valid after edge N.
- With FIFO_VR_OUT_REG_EN: a write accepted at edge N reaches the output register at edge N+1, and m_valid_o goes high after edge N+1.
- Sustained throughput is 1 transfer per cycle in both modes, with continuous s_valid_i and m_ready_i.
- Ordering is strict FIFO. There is no duplication or loss except on flush or reset.

## Configuration
- FIFO_VR_OUT_REG_EN defined: m_data_o and m_valid_o come from a prefetch output register, so there is no combinational path from memory to the outputs.
  - The register loads from memory when it is empty or is being read in the same cycle.
  - Capacity is FIFO_DEPTH+1, and count_o includes the register entry.
  - s_ready_o still reflects memory-full only.
- FIFO_VR_OUT_REG_EN undefined: m_data_o = mem[rd_ptr low bits] combinationally, m_valid_o = !empty, and capacity is FIFO_DEPTH.

## Test plan
- Reset with s_valid_i=1: s_ready_o=0 and m_valid_o=0 during reset. After reset, count_o=0 and almost_empty_o=1.
- Fill: write 0x01..0x20 with m_ready_i=0 (DEPTH 32, no macro). Required: s_ready_o falls after the 32nd accept, count_o=32, max_count_o=32. The extra write 0x21 is held, not accepted.
- Drain and wrap: read all entries. Required: 0x01..0x20 in order, m_valid_o low after the last read. Then write/read 40 more entries and check order across the pointer wrap.
- Simultaneous: at count_o=5, issue read+write in one cycle. Required: count_o stays 5. At full, read+write gives a read only and count_o=31.
- Thresholds: af=4, ae=1. Required: almost_full_o rises as count_o goes 3->4 and almost_empty_o falls as count_o goes 1->2. Changing af to 2 at count 3 raises almost_full_o the same cycle.
- Flush with concurrent write at count_o=7. Required: the next cycle shows count_o=0, max_count_o=0, m_valid_o=0, and the write is dropped. With the macro, repeat the fill and check capacity 33 and latency 2.
